// File: rtl/axi_expand_pkg.sv
// Shared constants for the axi_expand widening stage: dither LFSR taps,
// fill-mode encodings and the LFSR step function.
package axi_expand_pkg;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        FILL_ZERO   = 2'd0,
        FILL_HALF   = 2'd1,
        FILL_DITHER = 2'd2
    } fill_mode_e;

    // Galois step: shift right, fold the taps in when the dropped bit was set.
    function automatic logic [31:0] lfsr_next(input logic [31:0] value);
        return (value >> 1) ^ (value[0] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/axi_expand_buf.sv
// Two-entry stream FIFO with registered ready and valid; the write side never
// sees a combinational path from the read-side ready.
module axi_expand_buf
    import axi_expand_pkg::*;
#(
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready
);

    logic [1:0]       count_r;
    logic [1:0]       count_nxt_s;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] head_nxt_s;
    logic [WIDTH-1:0] tail_r;
    logic [WIDTH-1:0] tail_nxt_s;
    logic             ready_r;
    logic             valid_r;
    logic             push_s;
    logic             pop_s;

    // Next-state of occupancy and storage; head always holds the oldest entry.
    always_comb begin
        push_s      = wr_valid & ready_r;
        pop_s       = valid_r & rd_ready;
        count_nxt_s = count_r;
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        if (clear) begin
            count_nxt_s = 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_nxt_s = wr_data;
                    end else begin
                        tail_nxt_s = wr_data;
                    end
                    count_nxt_s = count_r + 2'd1;
                end
                2'b01: begin
                    head_nxt_s  = tail_r;
                    count_nxt_s = count_r - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; at count 1 the new beat lands straight in head.
                    if (count_r == 2'd1) begin
                        head_nxt_s = wr_data;
                    end else begin
                        head_nxt_s = tail_r;
                        tail_nxt_s = wr_data;
                    end
                end
                default: begin
                    count_nxt_s = count_r;
                end
            endcase
        end
    end

    // Storage, occupancy and the registered handshake flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= 2'd0;
            head_r  <= '0;
            tail_r  <= '0;
            ready_r <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            ready_r <= (count_nxt_s != 2'd2);
            valid_r <= (count_nxt_s != 2'd0);
        end
    end

    assign wr_ready = ready_r;
    assign rd_valid = valid_r;
    assign rd_data  = head_r;

endmodule

// File: rtl/axi_expand.sv
// Widens narrow signed stream samples by MSB-aligning them into WIDTH_OUT bits
// and filling the vacated LSBs with zeros, a half-LSB offset or LFSR dither.
module axi_expand
    import axi_expand_pkg::*;
#(
    parameter int          WIDTH_IN  = 16,
    parameter int          WIDTH_OUT = 24,
    parameter int          FILL_MODE = 0,
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic [WIDTH_IN-1:0]  i_tdata,
    input  logic                 i_tlast,
    input  logic                 i_tvalid,
    output logic                 i_tready,
    output logic [WIDTH_OUT-1:0] o_tdata,
    output logic                 o_tlast,
    output logic                 o_tvalid,
    input  logic                 o_tready
);

    localparam int PAD = WIDTH_OUT - WIDTH_IN;

    if (PAD < 1) begin : g_bad_width
        $error("axi_expand: WIDTH_OUT must exceed WIDTH_IN");
    end
    if (FILL_MODE > int'(FILL_DITHER) || FILL_MODE < 0) begin : g_bad_mode
        $error("axi_expand: unsupported FILL_MODE");
    end
    if (FILL_MODE == int'(FILL_DITHER) && PAD > 32) begin : g_bad_pad
        $error("axi_expand: dither fill limited to 32 pad bits");
    end
    if (LFSR_SEED == 32'h0000_0000) begin : g_bad_seed
        $error("axi_expand: LFSR_SEED must be nonzero");
    end

    logic [PAD-1:0] fill_s;

    if (FILL_MODE == int'(FILL_DITHER)) begin : g_dither
        logic [31:0] lfsr_r;
        logic        push_s;

        assign push_s = i_tvalid & i_tready;
        assign fill_s = lfsr_r[PAD-1:0];

        // Dither source; the fill uses the value held before this sample's advance.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                lfsr_r <= LFSR_SEED;
            end else if (clear) begin
                lfsr_r <= LFSR_SEED;
            end else if (push_s) begin
                lfsr_r <= lfsr_next(lfsr_r);
            end else begin
                lfsr_r <= lfsr_r;
            end
        end
    end else if (FILL_MODE == int'(FILL_HALF)) begin : g_half
        // Centre the widened value within the range of the dropped LSBs.
        always_comb begin
            fill_s          = '0;
            fill_s[PAD-1]   = 1'b1;
        end
    end else begin : g_zero
        assign fill_s = '0;
    end

    logic [WIDTH_OUT:0] rd_word_s;

    axi_expand_buf #(
        .WIDTH (WIDTH_OUT + 1)
    ) u_buf (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .wr_data  ({i_tlast, i_tdata, fill_s}),
        .wr_valid (i_tvalid),
        .wr_ready (i_tready),
        .rd_data  (rd_word_s),
        .rd_valid (o_tvalid),
        .rd_ready (o_tready)
    );

    assign o_tlast = rd_word_s[WIDTH_OUT];
    assign o_tdata = rd_word_s[WIDTH_OUT-1:0];

endmodule

// File: tb/tb_axi_expand.sv
// Bench for axi_expand: three instances (zero, half, dither fill) share one
// stimulus stream; directed vectors plus a scoreboarded random run.
module tb_axi_expand;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic [15:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        o_tready;

    logic        rdy_z, rdy_h, rdy_d;
    logic [23:0] dat_z, dat_h, dat_d;
    logic        lst_z, lst_h, lst_d;
    logic        vld_z, vld_h, vld_d;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi_expand #(.WIDTH_IN(16), .WIDTH_OUT(24), .FILL_MODE(0), .LFSR_SEED(32'h0000_0001)) u_zero (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(rdy_z),
        .o_tdata(dat_z), .o_tlast(lst_z), .o_tvalid(vld_z), .o_tready(o_tready));

    axi_expand #(.WIDTH_IN(16), .WIDTH_OUT(24), .FILL_MODE(1), .LFSR_SEED(32'h0000_0001)) u_half (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(rdy_h),
        .o_tdata(dat_h), .o_tlast(lst_h), .o_tvalid(vld_h), .o_tready(o_tready));

    axi_expand #(.WIDTH_IN(16), .WIDTH_OUT(24), .FILL_MODE(2), .LFSR_SEED(32'h0000_0001)) u_dith (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(rdy_d),
        .o_tdata(dat_d), .o_tlast(lst_d), .o_tvalid(vld_d), .o_tready(o_tready));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] data, input logic last);
        i_tdata  = data;
        i_tlast  = last;
        i_tvalid = 1'b1;
        tick();
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        logic [31:0] s;
        s = {1'b0, v[31:1]};
        if (v[0]) s = s ^ 32'h8020_0003;
        return s;
    endfunction

    initial begin
        #990_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] q[$];
        logic [24:0] e;
        logic [31:0] mlfsr;
        int          pushed;
        int          popped;
        int          cyc;

        reset_n  = 1'b0;
        clear    = 1'b0;
        i_tdata  = 16'h0000;
        i_tlast  = 1'b0;
        i_tvalid = 1'b0;
        o_tready = 1'b0;
        repeat (2) tick();
        chk("rst_vld",  {vld_z, vld_h, vld_d}, 3'b000);
        chk("rst_rdy",  {rdy_z, rdy_h, rdy_d}, 3'b000);
        chk("rst_data", dat_d, 24'h000000);
        chk("rst_last", lst_z, 1'b0);
        reset_n = 1'b1;
        chk("rdy_before_edge", rdy_z, 1'b0);
        tick();
        chk("rdy_up", {rdy_z, rdy_h, rdy_d}, 3'b111);

        // Zero fill, one beat per clock, latency 1
        o_tready = 1'b1;
        send(16'h8001, 1'b0);
        chk("zero0", {vld_z, dat_z}, {1'b1, 24'h800100});
        send(16'h7FFF, 1'b0);
        chk("zero1", {vld_z, dat_z}, {1'b1, 24'h7FFF00});
        send(16'h0000, 1'b0);
        chk("zero2", {vld_z, dat_z}, {1'b1, 24'h000000});
        i_tvalid = 1'b0;
        tick();
        chk("zero_drain", vld_z, 1'b0);

        // Half-LSB fill with tlast on the second beat only
        send(16'h7FFF, 1'b0);
        chk("half0", {vld_h, lst_h, dat_h}, {1'b1, 1'b0, 24'h7FFF80});
        send(16'hFFFF, 1'b1);
        chk("half1", {vld_h, lst_h, dat_h}, {1'b1, 1'b1, 24'hFFFF80});
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        tick();

        // Dither: clear drops the offered beat and reseeds
        clear    = 1'b1;
        i_tvalid = 1'b1;
        i_tdata  = 16'hAAAA;
        tick();
        clear    = 1'b0;
        i_tvalid = 1'b0;
        chk("clr_drop", {vld_z, vld_d}, 2'b00);
        send(16'h1234, 1'b0);
        chk("dith0", {vld_d, dat_d}, {1'b1, 24'h123401});
        send(16'h1234, 1'b0);
        chk("dith1", {vld_d, dat_d}, {1'b1, 24'h123403});
        send(16'h1234, 1'b0);
        chk("dith2", {vld_d, dat_d}, {1'b1, 24'h123402});
        i_tvalid = 1'b0;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        send(16'h1234, 1'b0);
        chk("dith_reseed", {vld_d, dat_d}, {1'b1, 24'h123401});
        i_tvalid = 1'b0;
        tick();

        // Backpressure: two accepted, third waits for the first pop
        o_tready = 1'b0;
        send(16'h1111, 1'b0);
        chk("bp_rdy1", rdy_z, 1'b1);
        send(16'h2222, 1'b0);
        chk("bp_rdy2", rdy_z, 1'b0);
        chk("bp_head", {vld_z, dat_z}, {1'b1, 24'h111100});
        i_tdata = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_stall", {vld_z, dat_z, rdy_z}, {1'b1, 24'h111100, 1'b0});
        end
        o_tready = 1'b1;
        tick();
        chk("bp_pop1", {vld_z, dat_z, rdy_z}, {1'b1, 24'h222200, 1'b1});
        tick();
        chk("bp_third", {vld_z, dat_z}, {1'b1, 24'h333300});
        i_tvalid = 1'b0;
        tick();
        chk("bp_drain", vld_z, 1'b0);

        // Random stress with scoreboard across all three fill modes
        clear = 1'b1;
        tick();
        clear  = 1'b0;
        mlfsr  = 32'h0000_0001;
        pushed = 0;
        popped = 0;
        cyc    = 0;
        while ((pushed < 10000 || q.size() != 0) && cyc < 80000) begin
            i_tvalid = (pushed < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            i_tdata  = 16'($urandom);
            i_tlast  = 1'($urandom_range(0, 1));
            o_tready = 1'($urandom_range(0, 1));
            if (vld_z && o_tready) begin
                chk("sb_nonempty", (q.size() != 0), 1'b1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("sb_zero", {lst_z, dat_z}, {e[24:8], 8'h00});
                    chk("sb_half", {lst_h, dat_h}, {e[24:8], 8'h80});
                    chk("sb_dith", {lst_d, dat_d}, e);
                    popped++;
                end
            end
            if (i_tvalid && rdy_z) begin
                q.push_back({i_tlast, i_tdata, mlfsr[7:0]});
                mlfsr = lfsr_step(mlfsr);
                pushed++;
            end
            tick();
            cyc++;
        end
        chk("sb_in_time", (cyc < 80000), 1'b1);
        chk("sb_count", popped, 10000);
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        tick();
        chk("sb_idle", {vld_z, vld_h, vld_d}, 3'b000);

        // Asynchronous reset with a full buffer
        o_tready = 1'b0;
        send(16'h4444, 1'b0);
        send(16'h5555, 1'b0);
        i_tvalid = 1'b0;
        chk("arst_full", {vld_d, rdy_d}, 2'b10);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_vld", {vld_z, vld_d}, 2'b00);
        chk("arst_rdy", {rdy_z, rdy_d}, 2'b00);
        tick();
        reset_n = 1'b1;
        tick();
        chk("arst_rdy_up", rdy_d, 1'b1);
        chk("arst_empty", vld_d, 1'b0);
        o_tready = 1'b1;
        send(16'h1234, 1'b0);
        chk("arst_first_z", {vld_z, dat_z}, {1'b1, 24'h123400});
        chk("arst_first_d", {vld_d, dat_d}, {1'b1, 24'h123401});
        i_tvalid = 1'b0;
        tick();
        chk("arst_drain", vld_d, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
